// File: rtl/legv8_register_file_pkg.sv
// Shared LEGv8 register-file definitions: architectural widths, the XZR index
// and the address/data types used across the register file slice.
package legv8_pkg;

    localparam int              REG_ADDR_W = 5;
    localparam int              XLEN       = 64;
    localparam logic [4:0]      XZR_IDX    = 5'd31;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

endpackage : legv8_pkg

// File: rtl/legv8_register_file_if.sv
// Register-file access bundle: two read ports, one write port and a debug peek.
// The master side (decode/writeback or a bench) drives addresses and write data;
// the slave side (the register file) returns read data.
interface legv8_register_file_if
    import legv8_pkg::*;
#(
    parameter int DATA_W = XLEN,
    parameter int ADDR_W = REG_ADDR_W
);

    logic [ADDR_W-1:0] ReadReg1;
    logic [ADDR_W-1:0] ReadReg2;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic              RegWrite;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic [ADDR_W-1:0] DbgReg;
    logic [DATA_W-1:0] DbgData;

    modport master (
        output ReadReg1, ReadReg2, WriteReg, WriteData, RegWrite, DbgReg,
        input  ReadData1, ReadData2, DbgData
    );

    modport slave (
        input  ReadReg1, ReadReg2, WriteReg, WriteData, RegWrite, DbgReg,
        output ReadData1, ReadData2, DbgData
    );

endinterface : legv8_register_file_if

// File: rtl/legv8_register_file_chk.sv
// Simulation-only checks for the register file: write address must be known
// when a write is strobed, and reads of X31 must return zero.
module legv8_register_file_chk
    import legv8_pkg::*;
#(
    parameter int DATA_W = XLEN,
    parameter int ADDR_W = REG_ADDR_W
) (
    input logic              clk,
    input logic              reset,
    input logic              regWrite,
    input logic [ADDR_W-1:0] writeReg,
    input logic [ADDR_W-1:0] readReg1,
    input logic [ADDR_W-1:0] readReg2,
    input logic [DATA_W-1:0] readData1,
    input logic [DATA_W-1:0] readData2
);

    localparam logic [ADDR_W-1:0] XZR_ADDR = {ADDR_W{1'b1}};

    // A strobed write with an unknown destination is a producer bug, not masked here.
    writeRegKnown_a: assert property (@(posedge clk) disable iff (reset)
        regWrite |-> !$isunknown(writeReg));

    // X31 always reads as zero on port 1.
    xzrPort1_a: assert property (@(posedge clk)
        (readReg1 == XZR_ADDR) |-> (readData1 == {DATA_W{1'b0}}));

    // X31 always reads as zero on port 2.
    xzrPort2_a: assert property (@(posedge clk)
        (readReg2 == XZR_ADDR) |-> (readData2 == {DATA_W{1'b0}}));

endmodule : legv8_register_file_chk

// File: rtl/legv8_register_file_read_port.sv
// One combinational read port: forces XZR to zero and, when BYPASS is set,
// forwards the in-flight write data for a matching address.
module regfile_read_port
    import legv8_pkg::*;
#(
    parameter int DATA_W = XLEN,
    parameter int ADDR_W = REG_ADDR_W,
    parameter bit BYPASS = 1'b1
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] storeData,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic              wrEn,
    output logic [DATA_W-1:0] rdData
);

    localparam logic [ADDR_W-1:0] XZR_ADDR = {ADDR_W{1'b1}};

    logic bypassHit_s;

    // XZR takes priority over forwarding so X31 reads zero even during a write to it.
    always_comb begin
        bypassHit_s = BYPASS && wrEn && (wrAddr == addr);
        rdData      = storeData;
        if (addr == XZR_ADDR) begin
            rdData = {DATA_W{1'b0}};
        end else if (bypassHit_s) begin
            rdData = wrData;
        end else begin
            rdData = storeData;
        end
    end

endmodule : regfile_read_port

// File: rtl/legv8_register_file.sv
// LEGv8 integer register file: 31 stored 64-bit registers (X0..X30) plus the
// hard-wired XZR, two combinational read ports with optional same-cycle
// write forwarding, one write port and a non-forwarding debug peek port.
module legv8_register_file
    import legv8_pkg::*;
#(
    parameter int DATA_W = XLEN,
    parameter int ADDR_W = REG_ADDR_W,
    parameter bit BYPASS = 1'b1
) (
    input logic                  clk,
    input logic                  reset,
    legv8_register_file_if.slave rf
);

    localparam int                NUM_REGS = (32'sd1 << ADDR_W) - 32'sd1;
    localparam logic [ADDR_W-1:0] XZR_ADDR = {ADDR_W{1'b1}};

    logic [DATA_W-1:0] regFile_r [0:NUM_REGS-1];

    logic [DATA_W-1:0] store1_s;
    logic [DATA_W-1:0] store2_s;
    logic [DATA_W-1:0] storeDbg_s;
    logic              writeEn_s;

    // Storage: async clear of X0..X30; writes to XZR are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 32'sd0; i < NUM_REGS; i = i + 32'sd1) begin
                regFile_r[i] <= {DATA_W{1'b0}};
            end
        end else if (rf.RegWrite && (rf.WriteReg != XZR_ADDR)) begin
            regFile_r[rf.WriteReg] <= rf.WriteData;
        end
    end

    // Raw storage lookups; X31 has no storage entry so it is zeroed before indexing.
    always_comb begin
        store1_s   = {DATA_W{1'b0}};
        store2_s   = {DATA_W{1'b0}};
        storeDbg_s = {DATA_W{1'b0}};
        if (rf.ReadReg1 != XZR_ADDR) begin
            store1_s = regFile_r[rf.ReadReg1];
        end else begin
            store1_s = {DATA_W{1'b0}};
        end
        if (rf.ReadReg2 != XZR_ADDR) begin
            store2_s = regFile_r[rf.ReadReg2];
        end else begin
            store2_s = {DATA_W{1'b0}};
        end
        if (rf.DbgReg != XZR_ADDR) begin
            storeDbg_s = regFile_r[rf.DbgReg];
        end else begin
            storeDbg_s = {DATA_W{1'b0}};
        end
    end

    // Forwarding is suppressed during reset so all ports read zero while it is held.
    assign writeEn_s = rf.RegWrite & ~reset;

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) uReadPort1 (
        .addr      (rf.ReadReg1),
        .storeData (store1_s),
        .wrAddr    (rf.WriteReg),
        .wrData    (rf.WriteData),
        .wrEn      (writeEn_s),
        .rdData    (rf.ReadData1)
    );

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) uReadPort2 (
        .addr      (rf.ReadReg2),
        .storeData (store2_s),
        .wrAddr    (rf.WriteReg),
        .wrData    (rf.WriteData),
        .wrEn      (writeEn_s),
        .rdData    (rf.ReadData2)
    );

    // Debug peek sees committed storage only, never the in-flight write.
    assign rf.DbgData = storeDbg_s;

    legv8_register_file_chk #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) uChk (
        .clk       (clk),
        .reset     (reset),
        .regWrite  (rf.RegWrite),
        .writeReg  (rf.WriteReg),
        .readReg1  (rf.ReadReg1),
        .readReg2  (rf.ReadReg2),
        .readData1 (rf.ReadData1),
        .readData2 (rf.ReadData2)
    );

endmodule : legv8_register_file

// File: tb/tb_legv8_register_file.sv
// Directed bench for legv8_register_file: one forwarding instance (BYPASS=1)
// and one non-forwarding instance (BYPASS=0) driven with identical stimulus.
module tb_legv8_register_file;
    import legv8_pkg::*;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    legv8_register_file_if #(.DATA_W(64), .ADDR_W(5)) ifB ();
    legv8_register_file_if #(.DATA_W(64), .ADDR_W(5)) ifN ();

    legv8_register_file #(.DATA_W(64), .ADDR_W(5), .BYPASS(1'b1)) dutB (
        .clk   (clk),
        .reset (reset),
        .rf    (ifB.slave)
    );

    legv8_register_file #(.DATA_W(64), .ADDR_W(5), .BYPASS(1'b0)) dutN (
        .clk   (clk),
        .reset (reset),
        .rf    (ifN.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive identical inputs into both instances.
    task automatic setIn(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dbg);
        ifB.RegWrite = we;  ifN.RegWrite = we;
        ifB.WriteReg = wa;  ifN.WriteReg = wa;
        ifB.WriteData = wd; ifN.WriteData = wd;
        ifB.ReadReg1 = r1;  ifN.ReadReg1 = r1;
        ifB.ReadReg2 = r2;  ifN.ReadReg2 = r2;
        ifB.DbgReg = dbg;   ifN.DbgReg = dbg;
    endtask

    // One write committed at the next rising edge; returns at the following negedge.
    task automatic doWrite(input logic [4:0] wa, input logic [63:0] wd);
        @(negedge clk);
        setIn(1'b1, wa, wd, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        setIn(1'b0, 5'd0, 64'd0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic test_reset();
        logic [4:0] a;
        for (int i = 0; i < 31; i++) begin
            a = i[4:0];
            doWrite(a, 64'hFFFF_FFFF_FFFF_FFFF);
        end
        setIn(1'b0, 5'd0, 64'd0, 5'd5, 5'd30, 5'd17);
        #1;
        checks++;
        if (ifB.DbgData !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++;
            $display("FAIL prefill_dbg: got %h expected %h", ifB.DbgData, 64'hFFFF_FFFF_FFFF_FFFF);
        end
        // Assert reset between edges, with a write strobe and a matching read in flight.
        #1;
        setIn(1'b1, 5'd5, 64'h1234, 5'd5, 5'd30, 5'd0);
        reset = 1'b1;
        #1;
        checks++;
        if (ifB.ReadData1 !== 64'd0) begin
            errors++;
            $display("FAIL reset_rd1_bypass: got %h expected %h", ifB.ReadData1, 64'd0);
        end
        checks++;
        if (ifB.ReadData2 !== 64'd0) begin
            errors++;
            $display("FAIL reset_rd2: got %h expected %h", ifB.ReadData2, 64'd0);
        end
        checks++;
        if (ifN.ReadData1 !== 64'd0) begin
            errors++;
            $display("FAIL reset_rd1_nobyp: got %h expected %h", ifN.ReadData1, 64'd0);
        end
        for (int i = 0; i < 32; i++) begin
            a = i[4:0];
            ifB.DbgReg = a;
            #0.1;
            checks++;
            if (ifB.DbgData !== 64'd0) begin
                errors++;
                $display("FAIL reset_dbg[%0d]: got %h expected %h", i, ifB.DbgData, 64'd0);
            end
        end
        @(negedge clk);
        setIn(1'b0, 5'd0, 64'd0, 5'd5, 5'd5, 5'd5);
        reset = 1'b0;
        #1;
        checks++;
        if (ifB.DbgData !== 64'd0) begin
            errors++;
            $display("FAIL reset_write_dropped: got %h expected %h", ifB.DbgData, 64'd0);
        end
    endtask

    task automatic test_write_read();
        doWrite(5'd5, 64'h0123_4567_89AB_CDEF);
        setIn(1'b0, 5'd0, 64'd0, 5'd5, 5'd5, 5'd5);
        #1;
        checks++;
        if (ifB.ReadData1 !== 64'h0123_4567_89AB_CDEF) begin
            errors++;
            $display("FAIL wr_rd1: got %h expected %h", ifB.ReadData1, 64'h0123_4567_89AB_CDEF);
        end
        checks++;
        if (ifB.ReadData2 !== 64'h0123_4567_89AB_CDEF) begin
            errors++;
            $display("FAIL wr_rd2: got %h expected %h", ifB.ReadData2, 64'h0123_4567_89AB_CDEF);
        end
        checks++;
        if (ifN.ReadData2 !== 64'h0123_4567_89AB_CDEF) begin
            errors++;
            $display("FAIL wr_rd2_nobyp: got %h expected %h", ifN.ReadData2, 64'h0123_4567_89AB_CDEF);
        end
    endtask

    task automatic test_xzr();
        doWrite(5'd30, 64'h3030);
        @(negedge clk);
        setIn(1'b1, 5'd31, 64'hDEAD, 5'd30, 5'd31, 5'd31);
        #1;
        checks++;
        if (ifB.ReadData2 !== 64'd0) begin
            errors++;
            $display("FAIL xzr_no_bypass: got %h expected %h", ifB.ReadData2, 64'd0);
        end
        @(negedge clk);
        setIn(1'b0, 5'd0, 64'd0, 5'd30, 5'd31, 5'd31);
        #1;
        checks++;
        if (ifB.ReadData2 !== 64'd0) begin
            errors++;
            $display("FAIL xzr_rd2: got %h expected %h", ifB.ReadData2, 64'd0);
        end
        checks++;
        if (ifB.ReadData1 !== 64'h3030) begin
            errors++;
            $display("FAIL xzr_x30_kept: got %h expected %h", ifB.ReadData1, 64'h3030);
        end
        checks++;
        if (ifB.DbgData !== 64'd0) begin
            errors++;
            $display("FAIL xzr_dbg: got %h expected %h", ifB.DbgData, 64'd0);
        end
    endtask

    task automatic test_bypass();
        doWrite(5'd7, 64'h11);
        @(negedge clk);
        setIn(1'b1, 5'd7, 64'h55, 5'd0, 5'd7, 5'd7);
        #1;
        checks++;
        if (ifB.ReadData2 !== 64'h55) begin
            errors++;
            $display("FAIL bypass_on: got %h expected %h", ifB.ReadData2, 64'h55);
        end
        checks++;
        if (ifN.ReadData2 !== 64'h11) begin
            errors++;
            $display("FAIL bypass_off_old: got %h expected %h", ifN.ReadData2, 64'h11);
        end
        checks++;
        if (ifB.DbgData !== 64'h11) begin
            errors++;
            $display("FAIL dbg_no_bypass: got %h expected %h", ifB.DbgData, 64'h11);
        end
        @(negedge clk);
        setIn(1'b0, 5'd0, 64'd0, 5'd0, 5'd7, 5'd7);
        #1;
        checks++;
        if (ifN.ReadData2 !== 64'h55) begin
            errors++;
            $display("FAIL bypass_off_new: got %h expected %h", ifN.ReadData2, 64'h55);
        end
        checks++;
        if (ifB.DbgData !== 64'h55) begin
            errors++;
            $display("FAIL bypass_committed: got %h expected %h", ifB.DbgData, 64'h55);
        end
    endtask

    task automatic test_reg2loc_sweep();
        logic [4:0]  a;
        logic [63:0] e;
        doWrite(5'd20, 64'hA);
        doWrite(5'd3, 64'hB);
        for (int i = 0; i < 6; i++) begin
            a = (i % 2 == 0) ? 5'd20 : 5'd3;
            e = (i % 2 == 0) ? 64'hA : 64'hB;
            @(negedge clk);
            setIn(1'b0, 5'd0, 64'd0, 5'd0, a, 5'd0);
            #1;
            checks++;
            if (ifB.ReadData2 !== e) begin
                errors++;
                $display("FAIL sweep[%0d]: got %h expected %h", i, ifB.ReadData2, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        setIn(1'b1, 5'd12, 64'h1, 5'd0, 5'd0, 5'd12);
        @(negedge clk);
        setIn(1'b1, 5'd12, 64'h2, 5'd0, 5'd0, 5'd12);
        @(negedge clk);
        setIn(1'b1, 5'd12, 64'h3, 5'd12, 5'd12, 5'd12);
        #1;
        checks++;
        if (ifB.DbgData !== 64'h2) begin
            errors++;
            $display("FAIL b2b_last_wins: got %h expected %h", ifB.DbgData, 64'h2);
        end
        checks++;
        if (ifB.ReadData1 !== 64'h3 || ifB.ReadData2 !== 64'h3) begin
            errors++;
            $display("FAIL b2b_dual_bypass: got %h/%h expected %h", ifB.ReadData1, ifB.ReadData2, 64'h3);
        end
        checks++;
        if (ifN.ReadData1 !== 64'h2 || ifN.ReadData2 !== 64'h2) begin
            errors++;
            $display("FAIL b2b_dual_nobyp: got %h/%h expected %h", ifN.ReadData1, ifN.ReadData2, 64'h2);
        end
        @(negedge clk);
        setIn(1'b0, 5'd0, 64'd0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic test_reset_during_write();
        doWrite(5'd9, 64'h99);
        @(negedge clk);
        setIn(1'b1, 5'd9, 64'h77, 5'd9, 5'd9, 5'd9);
        #2;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        setIn(1'b0, 5'd0, 64'd0, 5'd9, 5'd9, 5'd9);
        #1;
        checks++;
        if (ifB.DbgData !== 64'd0) begin
            errors++;
            $display("FAIL reset_beats_write: got %h expected %h", ifB.DbgData, 64'd0);
        end
        checks++;
        if (ifN.ReadData1 !== 64'd0) begin
            errors++;
            $display("FAIL reset_beats_write_nobyp: got %h expected %h", ifN.ReadData1, 64'd0);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        setIn(1'b0, 5'd0, 64'd0, 5'd0, 5'd0, 5'd0);
        #1;
        checks++;
        if (ifB.ReadData1 !== 64'd0 || ifB.DbgData !== 64'd0) begin
            errors++;
            $display("FAIL init_reset: got %h/%h expected %h", ifB.ReadData1, ifB.DbgData, 64'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_write_read();
        test_xzr();
        test_bypass();
        test_reg2loc_sweep();
        test_back_to_back();
        test_reset_during_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_legv8_register_file
